key_debounce_repeat: RTL and testbench
======================================

# key_debounce_repeat

Per-key debouncer and auto-repeat generator for the Tetris control buttons. Sits directly downstream of the 100 Hz divider: it converts the divider's slow square wave into a one-cycle tick in the system clock domain. On that tick it samples the raw push-buttons and emits clean levels, press pulses and DAS/ARR auto-repeat pulses to the game-logic FSM.

## Interface
- `NKEYS`, 4, number of independent key channels
- `DEB_TICKS`, 2, consecutive agreeing 10 ms samples needed to accept a level change (≥1)
- `DAS_TICKS`, 17, ticks from accepted press to first repeat (≥1)
- `ARR_TICKS`, 5, ticks between subsequent repeats (≥1)

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `tick_100hz_in`  in  1  100 Hz square wave from the clock divider; the rising edge defines the tick
- `keys_raw`  in  NKEYS  raw active-high buttons, asynchronous, bouncy
- `key_level`  out  NKEYS  debounced level, registered
- `key_press`  out  NKEYS  one-`clk` pulse on accepted 0→1
- `key_repeat`  out  NKEYS  one-`clk` auto-repeat pulse while held

## Operation
- Tick: `tick_100hz_in` passes through a 2-flop synchronizer, then a rising-edge detector, giving an internal `tick` of one `clk` cycle.
- Edge detector is armed only after a synchronized 0 has been seen since reset. No spurious tick if the input is high at reset release.
- Each `keys_raw` bit passes through its own 2-flop synchronizer. Sampling occurs only on `tick`.
- Debounce counter `deb_cnt`, width `$clog2(DEB_TICKS+1)`, one per key, applied on `tick`:
  - sample == `key_level`: `deb_cnt` ← 0.
  - sample != level and `deb_cnt == DEB_TICKS-1`: level toggles, `deb_cnt` ← 0.
  - otherwise `deb_cnt` increments.
- Per-key repeat FSM:
  - IDLE (level 0): accepted press → `key_press` pulse, `rpt_cnt` ← 0, go to DAS.
  - DAS: each tick `rpt_cnt++`. When `rpt_cnt == DAS_TICKS-1` on a tick: `key_repeat` pulse, `rpt_cnt` ← 0, go to ARR.
  - ARR: each tick `rpt_cnt++`. When `rpt_cnt == ARR_TICKS-1`: `key_repeat` pulse, `rpt_cnt` ← 0, stay in ARR.
  - Accepted release in DAS or ARR: go to IDLE. Release has priority, so no repeat pulse is issued on that tick.
- Repeat counting starts on the tick after the press tick, so `key_press` and `key_repeat` never coincide.
- Channels are fully independent. Simultaneous presses each pulse in the same cycle.

## Timing
- Reset (async, `rst_n`=0): all synchronizers, counters, `key_level`, `key_press`, `key_repeat` = 0; FSMs in IDLE; edge detector disarmed.
- Internal `tick` = 3 `clk` after the `tick_100hz_in` rising edge.
- Outputs are registered and change on the `clk` edge after the `tick` cycle.
- `key_press` and `key_repeat` are exactly 1 cycle wide.
- Stable press: `key_press` follows on the DEB_TICKS-th tick whose sample is 1.
- First repeat: DAS_TICKS ticks after the press tick. Later repeats: every ARR_TICKS ticks.
- `rst_n` asserted mid-hold drops everything to 0 immediately. After release, a still-held key needs a fresh DEB_TICKS samples before it re-presses.

## Configuration
- `KEY_AUTO_REPEAT_EN` defined: DAS/ARR FSM and `rpt_cnt` are built as above.
- Not defined: the FSM reduces to a level-follower and `rpt_cnt` is absent. `key_repeat` is tied to 0, `DAS_TICKS`/`ARR_TICKS` are ignored, and `key_press`/`key_level` behaviour is unchanged.

## Structure
- Package `tetris_input_pkg`:
  - typedef `key_state_e` {IDLE, DAS, ARR}
  - default constants `DEB_TICKS_DEF`, `DAS_TICKS_DEF`, `ARR_TICKS_DEF`
- Sub-module `key_channel`: one key's synchronizer, debounce counter and repeat FSM, instantiated NKEYS times with a generate loop.
- The top holds the shared tick synchronizer and edge detector.

## Test plan
- Reset: hold `rst_n`=0 with `keys_raw`=4'hF and ticks running → all outputs 0. After release, no `key_press` before the 2nd tick.
- Clean press: `keys_raw[0]`=1 held, DEB=2 → `key_level[0]`=1 and a single 1-cycle `key_press[0]` after tick 2; other bits stay 0.
- Bounce: key0 samples 1,0,1,1 on consecutive ticks → `key_press[0]` only after the 4th tick, exactly once.
- Auto-repeat, DAS=17, ARR=5, key held 30 ticks: press at tick 2, `key_repeat` at ticks 19, 24, 29 → 3 pulses. Release (2 zero samples) → level 0, no further repeats.
- Simultaneous: keys 1 and 3 pressed in the same cycle → `key_press`=4'b1010 in one cycle. Independent repeat streams.
- Macro off: key held 40 ticks → `key_repeat` constantly 0; `key_press` unchanged.

Source files
------------

// File: rtl/tetris_input_pkg.sv
// Shared types and default timing constants for the Tetris key input path.
package tetris_input_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DAS  = 2'd1,
      ARR  = 2'd2
   } key_state_e;

   localparam int DEB_TICKS_DEF = 2;
   localparam int DAS_TICKS_DEF = 17;
   localparam int ARR_TICKS_DEF = 5;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, tick-sampled debouncer and, with
// KEY_AUTO_REPEAT_EN defined, the DAS/ARR auto-repeat FSM.
module key_channel
   import tetris_input_pkg::*;
#(
   parameter int DEB_TICKS = DEB_TICKS_DEF,
   parameter int DAS_TICKS = DAS_TICKS_DEF,
   parameter int ARR_TICKS = ARR_TICKS_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic key_raw,
   output logic key_level,
   output logic key_press,
   output logic key_repeat
);

   localparam int DW = $clog2(DEB_TICKS + 1);

   if (DEB_TICKS < 1 || DAS_TICKS < 1 || ARR_TICKS < 1) begin : g_bad_params
      $error("key_channel: tick counts must be at least 1");
   end

   logic          key_s1, key_s2;
   logic [DW-1:0] deb_cnt, deb_cnt_n;
   logic          level_n, press_n, repeat_n;
   logic          rise, fall;

`ifdef KEY_AUTO_REPEAT_EN
   localparam int RW = $clog2(max2(DAS_TICKS, ARR_TICKS) + 1);
   key_state_e    state, state_n;
   logic [RW-1:0] rpt_cnt, rpt_cnt_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rpt_cnt <= '0;
      end else begin
         state   <= state_n;
         rpt_cnt <= rpt_cnt_n;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1     <= 1'b0;
         key_s2     <= 1'b0;
         deb_cnt    <= '0;
         key_level  <= 1'b0;
         key_press  <= 1'b0;
         key_repeat <= 1'b0;
      end else begin
         key_s1     <= key_raw;
         key_s2     <= key_s1;
         deb_cnt    <= deb_cnt_n;
         key_level  <= level_n;
         key_press  <= press_n;
         key_repeat <= repeat_n;
      end
   end

   always_comb begin
      deb_cnt_n = deb_cnt;
      level_n   = key_level;
      rise      = 1'b0;
      fall      = 1'b0;
      if (tick) begin
         if (key_s2 == key_level) begin
            deb_cnt_n = '0;
         end else if (deb_cnt == DW'(DEB_TICKS - 1)) begin
            level_n   = key_s2;
            deb_cnt_n = '0;
            rise      = key_s2;
            fall      = ~key_s2;
         end else begin
            deb_cnt_n = deb_cnt + 1'b1;
         end
      end
      press_n = rise;
   end

`ifdef KEY_AUTO_REPEAT_EN
   // An accepted release wins over a repeat landing on the same tick.
   always_comb begin
      state_n   = state;
      rpt_cnt_n = rpt_cnt;
      repeat_n  = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_n   = DAS;
               rpt_cnt_n = '0;
            end
         end
         DAS: begin
            if (fall) begin
               state_n = IDLE;
            end else if (tick) begin
               if (rpt_cnt == RW'(DAS_TICKS - 1)) begin
                  repeat_n  = 1'b1;
                  rpt_cnt_n = '0;
                  state_n   = ARR;
               end else begin
                  rpt_cnt_n = rpt_cnt + 1'b1;
               end
            end
         end
         ARR: begin
            if (fall) begin
               state_n = IDLE;
            end else if (tick) begin
               if (rpt_cnt == RW'(ARR_TICKS - 1)) begin
                  repeat_n  = 1'b1;
                  rpt_cnt_n = '0;
               end else begin
                  rpt_cnt_n = rpt_cnt + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end
`else
   assign repeat_n = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_repeat.sv
// Tick synchronizer/edge detector shared by NKEYS key_channel instances.
// Auto-repeat is built only when KEY_AUTO_REPEAT_EN is defined.
module key_debounce_repeat
   import tetris_input_pkg::*;
#(
   parameter int NKEYS     = 4,
   parameter int DEB_TICKS = DEB_TICKS_DEF,
   parameter int DAS_TICKS = DAS_TICKS_DEF,
   parameter int ARR_TICKS = ARR_TICKS_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_100hz_in,
   input  logic [NKEYS-1:0] keys_raw,
   output logic [NKEYS-1:0] key_level,
   output logic [NKEYS-1:0] key_press,
   output logic [NKEYS-1:0] key_repeat
);

   logic       tick_s1, tick_s2, tick_prev, tick;
   logic       armed;
   logic [1:0] sync_full;

   // sync_full marks when tick_s2 holds a real sample rather than its reset
   // value, so a wave already high at reset release cannot arm the detector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_s1   <= 1'b0;
         tick_s2   <= 1'b0;
         tick_prev <= 1'b0;
         sync_full <= 2'b00;
         armed     <= 1'b0;
         tick      <= 1'b0;
      end else begin
         tick_s1   <= tick_100hz_in;
         tick_s2   <= tick_s1;
         tick_prev <= tick_s2;
         sync_full <= {sync_full[0], 1'b1};
         armed     <= armed | (sync_full[1] & ~tick_s2);
         tick      <= armed & tick_s2 & ~tick_prev;
      end
   end

   for (genvar i = 0; i < NKEYS; i++) begin : g_key
      key_channel #(
         .DEB_TICKS (DEB_TICKS),
         .DAS_TICKS (DAS_TICKS),
         .ARR_TICKS (ARR_TICKS)
      ) u_key_channel (
         .clk        (clk),
         .rst_n      (rst_n),
         .tick       (tick),
         .key_raw    (keys_raw[i]),
         .key_level  (key_level[i]),
         .key_press  (key_press[i]),
         .key_repeat (key_repeat[i])
      );
   end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Randomized and directed bench for key_debounce_repeat against a tick-level
// reference model (debounce run length, press tick index, DAS/ARR arithmetic).
module tb_key_debounce_repeat;

   localparam int N   = 4;
   localparam int DEB = 2;
   localparam int DAS = 17;
   localparam int ARR = 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         tick_in = 1'b0;
   logic [N-1:0] keys_raw = '0;
   logic [N-1:0] key_level, key_press, key_repeat;

   int total = 0;
   int bad   = 0;

   int m_run [N];
   bit m_lvl [N];
   int m_tp  [N];
   int m_tick;

   key_debounce_repeat #(
      .NKEYS     (N),
      .DEB_TICKS (DEB),
      .DAS_TICKS (DAS),
      .ARR_TICKS (ARR)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick_100hz_in (tick_in),
      .keys_raw      (keys_raw),
      .key_level     (key_level),
      .key_press     (key_press),
      .key_repeat    (key_repeat)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_tick = 0;
      for (int i = 0; i < N; i++) begin
         m_run[i] = 0;
         m_lvl[i] = 1'b0;
         m_tp[i]  = 0;
      end
   endtask

   task automatic model_step(input logic [N-1:0] k, output logic [N-1:0] ep,
                             output logic [N-1:0] er, output logic [N-1:0] lv);
      int d;
      m_tick++;
      for (int i = 0; i < N; i++) begin
         ep[i] = 1'b0;
         er[i] = 1'b0;
         if (k[i] != m_lvl[i]) m_run[i]++;
         else m_run[i] = 0;
         if (m_run[i] == DEB) begin
            m_lvl[i] = k[i];
            m_run[i] = 0;
            if (k[i]) begin
               ep[i]   = 1'b1;
               m_tp[i] = m_tick;
            end
         end
`ifdef KEY_AUTO_REPEAT_EN
         else if (m_lvl[i]) begin
            d = m_tick - m_tp[i];
            if (d >= DAS && ((d - DAS) % ARR) == 0) er[i] = 1'b1;
         end
`endif
         lv[i] = m_lvl[i];
      end
   endtask

   // One full period of the 100 Hz wave; keys are stable long before the rise.
   task automatic run_tick(input logic [N-1:0] k, input bit live);
      int pc [N];
      int rc [N];
      logic [N-1:0] ep, er, lv;
      for (int i = 0; i < N; i++) begin
         pc[i] = 0;
         rc[i] = 0;
      end
      keys_raw = k;
      for (int c = 0; c < 20; c++) begin
         if (c == 8) tick_in = 1'b1;
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            pc[i] += int'(key_press[i]);
            rc[i] += int'(key_repeat[i]);
         end
      end
      tick_in = 1'b0;
      if (live) model_step(k, ep, er, lv);
      else begin
         ep = '0;
         er = '0;
         lv = '0;
      end
      for (int i = 0; i < N; i++) begin
         check_val($sformatf("press[%0d]@t%0d", i, m_tick), pc[i], int'(ep[i]));
         check_val($sformatf("repeat[%0d]@t%0d", i, m_tick), rc[i], int'(er[i]));
         check_val($sformatf("level[%0d]@t%0d", i, m_tick), int'(key_level[i]), int'(lv[i]));
      end
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_level"}, int'(key_level), 0);
      check_val({tag, "_press"}, int'(key_press), 0);
      check_val({tag, "_repeat"}, int'(key_repeat), 0);
   endtask

   initial begin
      bit intended [N];
      logic [N-1:0] k;
      model_reset();

      // Reset held with keys down and the tick wave running.
      @(negedge clk);
      for (int t = 0; t < 3; t++) run_tick(4'hF, 1'b0);
      check_zero("in_reset");

      // Release reset while the wave is high: that level must not tick.
      tick_in = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check_zero("rst_rel_high");
      tick_in = 1'b0;
      repeat (2) @(negedge clk);

      // Hold all keys 30 ticks: press at 2, repeats at 19/24/29.
      for (int t = 0; t < 30; t++) run_tick(4'hF, 1'b1);
      for (int t = 0; t < 4; t++) run_tick(4'h0, 1'b1);

      // Bounce on key 0.
      run_tick(4'h1, 1'b1);
      run_tick(4'h0, 1'b1);
      run_tick(4'h1, 1'b1);
      run_tick(4'h1, 1'b1);
      for (int t = 0; t < 3; t++) run_tick(4'h1, 1'b1);
      for (int t = 0; t < 3; t++) run_tick(4'h0, 1'b1);

      // Keys 1 and 3 together, held past DAS plus a few ARR periods.
      for (int t = 0; t < 40; t++) run_tick(4'b1010, 1'b1);
      for (int t = 0; t < 3; t++) run_tick(4'h0, 1'b1);

      // Random presses, holds and single-sample glitches.
      for (int i = 0; i < N; i++) intended[i] = 1'b0;
      for (int t = 0; t < 200; t++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) intended[i] = ~intended[i];
            k[i] = intended[i] ^ ($urandom_range(0, 9) == 0);
         end
         run_tick(k, 1'b1);
      end
      for (int t = 0; t < 3; t++) run_tick(4'h0, 1'b1);

      // Reset in the middle of a hold, then a fresh debounce.
      for (int t = 0; t < 10; t++) run_tick(4'hF, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("mid_hold_rst");
      repeat (3) @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      for (int t = 0; t < 25; t++) run_tick(4'hF, 1'b1);
      for (int t = 0; t < 3; t++) run_tick(4'h0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
